// File: rtl/mlp_pkg.sv
// Package for the MLP result collector.
// Holds the collector FSM state type and the default geometry constants
// shared by the collector top and its serializer.
package mlp_pkg;

   localparam int DEF_DIM            = 16;
   localparam int DEF_DATA_W         = 16;
   localparam int DEF_ROWS_PER_ROUND = 2;
   localparam int DEF_OUT_W          = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_t;

endpackage

// File: rtl/mlp_result_serializer.sv
// mlp_result_serializer
// Streams the stored result matrix out as OUT_W-bit words, lowest word first.
// Owns the word counter, the valid/ready handshake and last-word generation.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_active          collector is in DRAIN; words are offered while high
//   i_mem             flattened matrix storage (element 0 in the low bits)
//   result_ready_i    downstream accepts the current word
//   result_valid_o    current word valid
//   result_payload_o  current word
//   result_last_o     current word is the final word of the matrix
//   o_last_hs         final word accepted this cycle
module mlp_result_serializer #(
   parameter  int MEM_W  = 4096,
   parameter  int OUT_W  = 32,
   localparam int NWORDS = MEM_W / OUT_W,
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_active,
   input  logic [MEM_W-1:0] i_mem,
   input  logic             result_ready_i,
   output logic             result_valid_o,
   output logic [OUT_W-1:0] result_payload_o,
   output logic             result_last_o,
   output logic             o_last_hs
);

   logic [CNT_W-1:0] r_word_cnt;
   logic             w_hs;
   int               w_bit_base;

   assign result_valid_o   = i_active;
   assign w_hs             = i_active & result_ready_i;
   assign result_last_o    = i_active && (r_word_cnt == CNT_W'(NWORDS - 1));
   assign o_last_hs        = w_hs & result_last_o;
   assign w_bit_base       = int'(r_word_cnt) * OUT_W;
   // Storage cannot change while draining, so the word stays stable across stalls.
   assign result_payload_o = i_mem[w_bit_base +: OUT_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_cnt <= '0;
      end else if (!i_active) begin
         r_word_cnt <= '0;
      end else if (w_hs) begin
         r_word_cnt <= result_last_o ? '0 : r_word_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mlp_result_collector.sv
// mlp_result_collector
// Collects a DIM x DIM result matrix delivered by the PE array in rounds of
// ROWS_PER_ROUND rows (any round order), then drains it as OUT_W-bit words.
// Optional feature: define MLP_RESULT_RELU_EN to zero negative elements at
// capture; without it stored data equals round_data_i bit-exactly.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           clear the round mask and begin a new matrix
//   round_valid_i     round_idx_i / round_data_i valid
//   round_idx_i       round number
//   round_data_i      ROWS_PER_ROUND rows, row r col c at [(r*DIM+c)*DATA_W +: DATA_W]
//   result_valid_o    output word valid
//   result_ready_i    downstream accepts the word
//   result_payload_o  packed output word
//   result_last_o     final word of the matrix
//   busy_o            collecting or draining
//   err_o             sticky protocol-error flag
module mlp_result_collector
   import mlp_pkg::*;
#(
   parameter  int DIM            = DEF_DIM,
   parameter  int DATA_W         = DEF_DATA_W,
   parameter  int ROWS_PER_ROUND = DEF_ROWS_PER_ROUND,
   parameter  int OUT_W          = DEF_OUT_W,
   localparam int NROUNDS        = DIM / ROWS_PER_ROUND,
   localparam int IDX_W          = (NROUNDS > 1) ? $clog2(NROUNDS) : 1,
   localparam int ROUND_W        = ROWS_PER_ROUND * DIM * DATA_W,
   localparam int MEM_W          = DIM * DIM * DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               round_valid_i,
   input  logic [IDX_W-1:0]   round_idx_i,
   input  logic [ROUND_W-1:0] round_data_i,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [OUT_W-1:0]   result_payload_o,
   output logic               result_last_o,
   output logic               busy_o,
   output logic               err_o
);

   if (DIM % ROWS_PER_ROUND != 0) begin : g_chk_rows
      $error("mlp_result_collector: DIM must be a multiple of ROWS_PER_ROUND");
   end
   if (OUT_W % DATA_W != 0) begin : g_chk_outw
      $error("mlp_result_collector: OUT_W must be a multiple of DATA_W");
   end
   if (MEM_W % OUT_W != 0) begin : g_chk_words
      $error("mlp_result_collector: matrix size must be a multiple of OUT_W");
   end

   state_t               r_state, w_state_nxt;
   logic [NROUNDS-1:0]   r_mask, w_mask_nxt, w_mask_base, w_onehot;
   logic                 r_err, w_err_nxt;
   logic                 w_capture, w_idx_ok, w_last_hs;
   logic [MEM_W-1:0]     r_mem;
   logic [ROUND_W-1:0]   w_capt_data;

`ifdef MLP_RESULT_RELU_EN
   function automatic logic [DATA_W-1:0] relu_elem(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? '0 : v;
   endfunction
`endif

   for (genvar gi = 0; gi < ROWS_PER_ROUND * DIM; gi++) begin : g_capt
`ifdef MLP_RESULT_RELU_EN
      assign w_capt_data[gi*DATA_W +: DATA_W] = relu_elem(round_data_i[gi*DATA_W +: DATA_W]);
`else
      assign w_capt_data[gi*DATA_W +: DATA_W] = round_data_i[gi*DATA_W +: DATA_W];
`endif
   end

   // Indices beyond the last round (non power-of-two round counts) are rejected.
   assign w_idx_ok = (int'(round_idx_i) < NROUNDS);
   assign w_onehot = w_idx_ok ? (NROUNDS'(1) << round_idx_i) : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_mask_base = r_mask;
      w_err_nxt   = r_err;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_mask_nxt  = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = COLLECT;
            end
            if (round_valid_i) w_err_nxt = 1'b1;
         end
         COLLECT: begin
            // A coincident start clears the mask before the round is recorded.
            if (start_i) w_mask_base = '0;
            w_mask_nxt = w_mask_base;
            if (round_valid_i) begin
               if (!w_idx_ok) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_capture  = 1'b1;
                  w_mask_nxt = w_mask_base | w_onehot;
                  if ((w_mask_base & w_onehot) != '0) w_err_nxt = 1'b1;
                  if (&(w_mask_base | w_onehot)) w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (round_valid_i || start_i) w_err_nxt = 1'b1;
            if (w_last_hs) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Matrix storage carries no reset; it is only read while draining.
   always_ff @(posedge clk) begin
      if (w_capture) r_mem[int'(round_idx_i)*ROUND_W +: ROUND_W] <= w_capt_data;
   end

   mlp_result_serializer #(
      .MEM_W (MEM_W),
      .OUT_W (OUT_W)
   ) u_serializer (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_active         (r_state == DRAIN),
      .i_mem            (r_mem),
      .result_ready_i   (result_ready_i),
      .result_valid_o   (result_valid_o),
      .result_payload_o (result_payload_o),
      .result_last_o    (result_last_o),
      .o_last_hs        (w_last_hs)
   );

   assign busy_o = (r_state != IDLE);
   assign err_o  = r_err;

endmodule

// File: tb/tb_mlp_result_collector.sv
// Testbench for mlp_result_collector (default geometry 16x16x16b, 32-bit words).
module tb_mlp_result_collector;

   localparam int DIM = 16;
   localparam int DW  = 16;
   localparam int RPR = 2;
   localparam int OW  = 32;
   localparam int NW  = DIM * DIM * DW / OW;
   localparam int EPW = OW / DW;

   typedef struct {
      logic [OW-1:0] p;
      logic          l;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start_i;
   logic                   round_valid_i;
   logic [2:0]             round_idx_i;
   logic [RPR*DIM*DW-1:0]  round_data_i;
   logic                   result_valid_o;
   logic                   result_ready_i;
   logic [OW-1:0]          result_payload_o;
   logic                   result_last_o;
   logic                   busy_o;
   logic                   err_o;

   int            n_checks = 0;
   int            n_fail   = 0;
   exp_t          sb[$];
   logic [DW-1:0] mdl [DIM][DIM];
   logic [OW-1:0] first_p, last_p;
   int            acc;

   always #5 clk = ~clk;

   mlp_result_collector dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .round_valid_i    (round_valid_i),
      .round_idx_i      (round_idx_i),
      .round_data_i     (round_data_i),
      .result_valid_o   (result_valid_o),
      .result_ready_i   (result_ready_i),
      .result_payload_o (result_payload_o),
      .result_last_o    (result_last_o),
      .busy_o           (busy_o),
      .err_o            (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] elem_val(input int mode, input int r, input int c);
      if (mode == 1) return 16'hAAAA;
      if (mode == 2 && r == 0 && c == 0) return 16'h8001;
      if (mode == 2 && r == 0 && c == 1) return 16'h7FFF;
      return 16'(r * 16 + c);
   endfunction

   function automatic logic [DW-1:0] model_cap(input logic [DW-1:0] v);
`ifdef MLP_RESULT_RELU_EN
      return v[DW-1] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic send_round(input int idx, input int mode);
      logic [DW-1:0] v;
      for (int rr = 0; rr < RPR; rr++) begin
         for (int c = 0; c < DIM; c++) begin
            v = elem_val(mode, idx * RPR + rr, c);
            round_data_i[(rr*DIM+c)*DW +: DW] = v;
            mdl[idx*RPR+rr][c] = model_cap(v);
         end
      end
      round_idx_i   = 3'(idx);
      round_valid_i = 1'b1;
      @(negedge clk);
      chk("valid_in_collect", {63'd0, result_valid_o}, 64'd0);
      @(posedge clk); #1;
      round_valid_i = 1'b0;
   endtask

   task automatic push_expected();
      exp_t e;
      int   k;
      for (int w = 0; w < NW; w++) begin
         e.p = '0;
         for (int j = 0; j < EPW; j++) begin
            k = w * EPW + j;
            e.p[j*DW +: DW] = mdl[k/DIM][k%DIM];
         end
         e.l = (w == NW - 1);
         sb.push_back(e);
      end
   endtask

   // mode 0: ready held high; mode 1: ready toggles each cycle.
   task automatic drain(input int mode, input int max_acc, input bit chk_first);
      int            cyc = 0;
      logic          held_v = 1'b0;
      logic [OW-1:0] held_p;
      logic          held_l;
      exp_t          e;
      acc = 0;
      while (acc < max_acc && sb.size() > 0 && cyc < 1000) begin
         result_ready_i = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         @(negedge clk);
         if (chk_first && cyc == 0) chk("first_valid", {63'd0, result_valid_o}, 64'd1);
         if (held_v) begin
            chk("stall_payload", {32'd0, result_payload_o}, {32'd0, held_p});
            chk("stall_last", {63'd0, result_last_o}, {63'd0, held_l});
         end
         held_v = 1'b0;
         if (result_valid_o) begin
            if (result_ready_i) begin
               e = sb.pop_front();
               chk("payload", {32'd0, result_payload_o}, {32'd0, e.p});
               chk("last", {63'd0, result_last_o}, {63'd0, e.l});
               if (acc == 0) first_p = result_payload_o;
               last_p = result_payload_o;
               acc++;
            end else begin
               held_v = 1'b1;
               held_p = result_payload_o;
               held_l = result_last_o;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("drain_complete", {63'd0, (acc == max_acc) || (sb.size() == 0)}, 64'd1);
      result_ready_i = 1'b1;
   endtask

   task automatic chk_idle(input string tag, input logic exp_err);
      @(negedge clk);
      chk({tag, "_valid"}, {63'd0, result_valid_o}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
      chk({tag, "_err"}, {63'd0, err_o}, {63'd0, exp_err});
      @(posedge clk); #1;
   endtask

   initial begin
      int order [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
      rst_n          = 1'b0;
      start_i        = 1'b0;
      round_valid_i  = 1'b0;
      round_idx_i    = '0;
      round_data_i   = '0;
      result_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
      chk("rst_last", {63'd0, result_last_o}, 64'd0);
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_err", {63'd0, err_o}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // In-order rounds, ready always high.
      pulse_start();
      @(negedge clk);
      chk("busy_after_start", {63'd0, busy_o}, 64'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send_round(i, 0);
      push_expected();
      drain(0, NW, 1'b1);
      chk("inorder_words", 64'(acc), 64'(NW));
      chk("inorder_word0", {32'd0, first_p}, 64'h0000_0000_0001_0000);
      chk("inorder_word127", {32'd0, last_p}, 64'h0000_0000_00FF_00FE);
      chk_idle("inorder_end", 1'b0);

      // A round while idle is an error; the next start clears it.
      send_round(0, 0);
      @(negedge clk);
      chk("idle_round_err", {63'd0, err_o}, 64'd1);
      @(posedge clk); #1;
      pulse_start();
      @(negedge clk);
      chk("start_clears_err", {63'd0, err_o}, 64'd0);
      @(posedge clk); #1;

      // Partial matrix, restart mid-collect, then scrambled round order.
      for (int i = 0; i < 4; i++) send_round(i, 1);
      pulse_start();
      for (int i = 0; i < 8; i++) send_round(order[i], 0);
      push_expected();
      drain(0, NW, 1'b1);
      chk("scrambled_words", 64'(acc), 64'(NW));
      chk("scrambled_word0", {32'd0, first_p}, 64'h0000_0000_0001_0000);
      chk_idle("scrambled_end", 1'b0);

      // Ready toggling during drain.
      pulse_start();
      for (int i = 0; i < 8; i++) send_round(i, 0);
      push_expected();
      drain(1, NW, 1'b1);
      chk("toggle_words", 64'(acc), 64'(NW));
      chk_idle("toggle_end", 1'b0);

      // Duplicate round 2 overwrites rows 4-5 and flags an error.
      pulse_start();
      for (int i = 0; i < 3; i++) send_round(i, 0);
      send_round(2, 1);
      @(negedge clk);
      chk("dup_err", {63'd0, err_o}, 64'd1);
      @(posedge clk); #1;
      for (int i = 3; i < 8; i++) send_round(i, 0);
      push_expected();
      drain(0, NW, 1'b1);
      chk("dup_words", 64'(acc), 64'(NW));
      chk_idle("dup_end", 1'b1);

      // Reset after 40 accepted words, then a fresh full matrix.
      pulse_start();
      for (int i = 0; i < 8; i++) send_round(i, 0);
      push_expected();
      drain(0, 40, 1'b1);
      chk("pre_reset_words", 64'(acc), 64'd40);
      rst_n = 1'b0;
      #1;
      chk("reset_valid", {63'd0, result_valid_o}, 64'd0);
      chk("reset_busy", {63'd0, busy_o}, 64'd0);
      chk("reset_last", {63'd0, result_last_o}, 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      for (int i = 0; i < 8; i++) send_round(i, 0);
      push_expected();
      drain(0, NW, 1'b1);
      chk("post_reset_words", 64'(acc), 64'(NW));
      chk("post_reset_word127", {32'd0, last_p}, 64'h0000_0000_00FF_00FE);
      chk_idle("post_reset_end", 1'b0);

`ifdef MLP_RESULT_RELU_EN
      // Negative element zeroed at capture, largest positive kept.
      pulse_start();
      for (int i = 0; i < 8; i++) send_round(i, 2);
      push_expected();
      drain(0, NW, 1'b1);
      chk("relu_word0", {32'd0, first_p}, 64'h0000_0000_7FFF_0000);
      chk_idle("relu_end", 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
